// File: rtl/vga_sync_tracker_if.sv
// Signal bundle between the sync pins (or generator loopback) and the sync tracker.
// The master drives the active-low syncs; the slave returns measurements and recovered timing.
interface vga_sync_tracker_if;
    logic        vga_h_sync;
    logic        vga_v_sync;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic        locked;
    logic [10:0] CounterX;
    logic [9:0]  CounterY;
    logic        inDisplayArea;
    logic        frame_start;

    modport master (
        output vga_h_sync,
        output vga_v_sync,
        input  line_len,
        input  frame_lines,
        input  locked,
        input  CounterX,
        input  CounterY,
        input  inDisplayArea,
        input  frame_start
    );

    modport slave (
        input  vga_h_sync,
        input  vga_v_sync,
        output line_len,
        output frame_lines,
        output locked,
        output CounterX,
        output CounterY,
        output inDisplayArea,
        output frame_start
    );
endinterface

// File: rtl/vga_sync_tracker.sv
// Follows foreign VGA timing: measures line/frame length from the incoming syncs,
// declares lock once both are stable, and regenerates pixel coordinates and a display flag.
module vga_sync_tracker #(
    parameter logic [10:0] H_BP     = 11'd64,
    parameter logic [10:0] H_ACTIVE = 11'd1280,
    parameter logic [9:0]  V_BP     = 10'd2,
    parameter logic [9:0]  V_ACTIVE = 10'd480,
    parameter int unsigned H_MATCH  = 3
) (
    input  logic              clk,
    input  logic              rst,
    vga_sync_tracker_if.slave sync_if
);

    localparam logic [10:0] X_MAX     = 11'h7FF;
    localparam logic [9:0]  Y_MAX     = 10'h3FF;
    localparam logic [2:0]  H_MATCH_N = 3'(H_MATCH);
    localparam logic [10:0] H_END     = H_BP + H_ACTIVE;
    localparam logic [9:0]  V_END     = V_BP + V_ACTIVE;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        H_OK   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic        h_meta_q, h_sync_q, h_hist_q;
    logic        v_meta_q, v_sync_q, v_hist_q;
    logic        hf, vf;

    logic [10:0] x_cnt_q, x_cnt_d;
    logic [9:0]  y_cnt_q, y_cnt_d;
    logic        x_to, y_to;

    logic [10:0] line_len_q, line_len_d, line_len_new;
    logic [9:0]  frame_lines_q, frame_lines_d, frame_lines_new;
    logic [2:0]  h_match_q, h_match_d;
    logic        h_eq, h_mismatch, v_same;

    logic [10:0] counter_x_q, counter_x_d;
    logic [9:0]  counter_y_q, counter_y_d;
    logic        disp_q, disp_d;
    logic        frame_start_q;

    // Syncs idle high, so the synchronizer and history come out of reset at 1
    // to avoid a false falling edge right after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_meta_q <= 1'b1;
            h_sync_q <= 1'b1;
            h_hist_q <= 1'b1;
            v_meta_q <= 1'b1;
            v_sync_q <= 1'b1;
            v_hist_q <= 1'b1;
        end else begin
            h_meta_q <= sync_if.vga_h_sync;
            h_sync_q <= h_meta_q;
            h_hist_q <= h_sync_q;
            v_meta_q <= sync_if.vga_v_sync;
            v_sync_q <= v_meta_q;
            v_hist_q <= v_sync_q;
        end
    end

    assign hf = ~h_sync_q & h_hist_q;
    assign vf = ~v_sync_q & v_hist_q;

    assign x_to = (x_cnt_q == X_MAX);
    assign y_to = (y_cnt_q == Y_MAX);

    assign line_len_new    = x_cnt_q + 11'd1;
    assign frame_lines_new = y_cnt_q + 10'd1;
    assign h_eq            = (line_len_new == line_len_q);
    assign h_mismatch      = hf & ~h_eq;
    assign v_same          = (frame_lines_new == frame_lines_q);

    always_comb begin
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        h_match_d     = h_match_q;

        if (hf) begin
            x_cnt_d = '0;
        end else if (!x_to) begin
            x_cnt_d = x_cnt_q + 11'd1;
        end

        // vf wins over a coincident hf; that hf is already counted in frame_lines_new
        if (vf) begin
            y_cnt_d = '0;
        end else if (hf && !y_to) begin
            y_cnt_d = y_cnt_q + 10'd1;
        end

        if (hf) begin
            line_len_d = line_len_new;
        end
        if (vf) begin
            frame_lines_d = frame_lines_new;
        end

        if (x_to || y_to) begin
            h_match_d = '0;
        end else if (hf) begin
            if (!h_eq) begin
                h_match_d = '0;
            end else if (h_match_q < H_MATCH_N) begin
                h_match_d = h_match_q + 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEARCH: begin
                if (h_match_q == H_MATCH_N && !h_mismatch) begin
                    state_d = H_OK;
                end
            end
            H_OK: begin
                if (h_mismatch) begin
                    state_d = SEARCH;
                end else if (vf && v_same) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (h_mismatch || (vf && !v_same)) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
        if (x_to || y_to) begin
            state_d = SEARCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Recovered outputs trail x_cnt/y_cnt by one register; consumers absorb it through H_BP.
    always_comb begin
        counter_x_d = x_cnt_q - H_BP;
        counter_y_d = y_cnt_q - V_BP;
        disp_d      = (state_q == LOCKED)
                    && (x_cnt_q >= H_BP) && (x_cnt_q < H_END)
                    && (y_cnt_q >= V_BP) && (y_cnt_q < V_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            h_match_q     <= '0;
            counter_x_q   <= '0;
            counter_y_q   <= '0;
            disp_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            h_match_q     <= h_match_d;
            counter_x_q   <= counter_x_d;
            counter_y_q   <= counter_y_d;
            disp_q        <= disp_d;
            frame_start_q <= vf;
        end
    end

    assign sync_if.line_len      = line_len_q;
    assign sync_if.frame_lines   = frame_lines_q;
    assign sync_if.locked        = (state_q == LOCKED);
    assign sync_if.CounterX      = counter_x_q;
    assign sync_if.CounterY      = counter_y_q;
    assign sync_if.inDisplayArea = disp_q;
    assign sync_if.frame_start   = frame_start_q;

endmodule
